// File: rtl/config_pkg.sv
// Shared configuration for the TLB CAM with SFENCE.VMA sweep.
// Holds default field widths and the flush sequencer state encoding.
package config_pkg;

  // Default VPN width: four 9-bit segments (SV48).
  localparam int unsigned VPN_BITS       = 36;
  localparam int unsigned ASID_BITS      = 16;
  localparam int unsigned PAGE_TYPE_BITS = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/tlb_cam_entry.sv
// One TLB CAM entry: storage for valid/G/ASID/VPN/page type plus the
// lookup and flush compare logic.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   we_i, inv_i             install (vpn_i/asid_i/g_i/page_type_i), invalidate (wins over we_i)
//   vpn_i, asid_i           lookup and install operands
//   flush_*_i               latched SFENCE.VMA operands and "any" qualifiers
//   valid_o, match_o        entry valid, lookup hit
//   flush_hit_o             entry selected by the current flush operands
//   page_type_o             stored page level
module tlb_cam_entry
  import config_pkg::PAGE_TYPE_BITS;
#(
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned SEGMENT_BITS = 9,
  parameter int unsigned ASID_BITS    = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           inv_i,
  input  logic [LEVELS*SEGMENT_BITS-1:0] vpn_i,
  input  logic [ASID_BITS-1:0]           asid_i,
  input  logic                           g_i,
  input  logic [PAGE_TYPE_BITS-1:0]      page_type_i,
  input  logic [LEVELS*SEGMENT_BITS-1:0] flush_vpn_i,
  input  logic [ASID_BITS-1:0]           flush_asid_i,
  input  logic                           flush_any_va_i,
  input  logic                           flush_any_asid_i,
  output logic                           valid_o,
  output logic                           match_o,
  output logic                           flush_hit_o,
  output logic [PAGE_TYPE_BITS-1:0]      page_type_o
);

  localparam int unsigned VpnBits = LEVELS * SEGMENT_BITS;

  logic                      valid_q;
  logic                      g_q;
  logic [VpnBits-1:0]        vpn_q;
  logic [ASID_BITS-1:0]      asid_q;
  logic [PAGE_TYPE_BITS-1:0] pt_q;

  // Invalidate takes priority so a write racing a full flush ends up invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (we_i) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      g_q    <= 1'b0;
      vpn_q  <= '0;
      asid_q <= '0;
      pt_q   <= '0;
    end else if (we_i) begin
      g_q    <= g_i;
      vpn_q  <= vpn_i;
      asid_q <= asid_i;
      pt_q   <= page_type_i;
    end
  end

  // Segments below the stored page level are page-offset bits and never compared.
  logic [LEVELS-1:0] seg_hit;
  logic [LEVELS-1:0] flush_seg_hit;

  for (genvar i = 0; i < LEVELS; i++) begin : g_seg
    logic ignore;
    assign ignore           = int'(pt_q) > i;
    assign seg_hit[i]       = ignore |
                              (vpn_q[i*SEGMENT_BITS +: SEGMENT_BITS] ==
                               vpn_i[i*SEGMENT_BITS +: SEGMENT_BITS]);
    assign flush_seg_hit[i] = ignore |
                              (vpn_q[i*SEGMENT_BITS +: SEGMENT_BITS] ==
                               flush_vpn_i[i*SEGMENT_BITS +: SEGMENT_BITS]);
  end

  assign valid_o     = valid_q;
  assign page_type_o = pt_q;
  assign match_o     = valid_q & (g_q | (asid_q == asid_i)) & (&seg_hit);
  // Global entries survive ASID-specific flushes.
  assign flush_hit_o = valid_q &
                       (flush_any_va_i | (&flush_seg_hit)) &
                       (flush_any_asid_i | (~g_q & (asid_q == flush_asid_i)));

endmodule

// File: rtl/tlb_cam_sweep.sv
// Fully associative TLB CAM with tree-PLRU replacement and a sequential
// SFENCE.VMA sweep engine.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   VPN, ASID, Lookup                lookup operands; Lookup qualifies PLRU update
//   Write, WriteG, WritePageType     install into the Victim entry
//   FlushReq, FlushAnyVA/ASID,
//   FlushVPN, FlushASID              SFENCE.VMA request and operands
//   FlushBusy, FlushDone             sweep in progress, one-cycle completion pulse
//   Matches, HitPageType, CAMHit     combinational lookup result
//   Victim                           one-hot entry the next Write fills
module tlb_cam_sweep #(
  parameter int unsigned TLB_ENTRIES  = 8,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned SEGMENT_BITS = 9,
  parameter int unsigned ASID_BITS    = config_pkg::ASID_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LEVELS*SEGMENT_BITS-1:0] VPN,
  input  logic [ASID_BITS-1:0]           ASID,
  input  logic                           Lookup,
  input  logic                           Write,
  input  logic                           WriteG,
  input  logic [1:0]                     WritePageType,
  input  logic                           FlushReq,
  input  logic                           FlushAnyVA,
  input  logic                           FlushAnyASID,
  input  logic [LEVELS*SEGMENT_BITS-1:0] FlushVPN,
  input  logic [ASID_BITS-1:0]           FlushASID,
  output logic                           FlushBusy,
  output logic                           FlushDone,
  output logic [TLB_ENTRIES-1:0]         Matches,
  output logic [1:0]                     HitPageType,
  output logic                           CAMHit,
  output logic [TLB_ENTRIES-1:0]         Victim
);

  import config_pkg::flush_state_e;
  import config_pkg::StIdle;
  import config_pkg::StSweep;
  import config_pkg::StDone;

  localparam int unsigned VpnBits  = LEVELS * SEGMENT_BITS;
  localparam int unsigned IdxBits  = $clog2(TLB_ENTRIES);
  localparam int unsigned TreeBits = TLB_ENTRIES - 1;

  // Tree nodes are heap-ordered (children of n at 2n+1, 2n+2); a node bit
  // gives the direction (0 = lower half) toward the replacement candidate.
  function automatic logic [TreeBits-1:0] plru_touch(input logic [TreeBits-1:0] tree,
                                                     input logic [IdxBits-1:0]  idx);
    logic [TreeBits-1:0] t;
    logic [IdxBits-1:0]  node;
    logic                dir;
    t    = tree;
    node = '0;
    for (int lvl = 0; lvl < IdxBits; lvl++) begin
      dir     = idx[IdxBits-1-lvl];
      t[node] = ~dir;
      node    = (node << 1) + IdxBits'(1) + IdxBits'(dir);
    end
    return t;
  endfunction

  function automatic logic [IdxBits-1:0] onehot_to_idx(input logic [TLB_ENTRIES-1:0] oh);
    logic [IdxBits-1:0] idx;
    idx = '0;
    for (int k = 0; k < TLB_ENTRIES; k++) begin
      if (oh[k]) idx |= IdxBits'(k);
    end
    return idx;
  endfunction

  flush_state_e          state_q, state_d;
  logic [IdxBits-1:0]    idx_q, idx_d;
  logic [TreeBits-1:0]   plru_q, plru_d;
  logic [VpnBits-1:0]    flush_vpn_q;
  logic [ASID_BITS-1:0]  flush_asid_q;
  logic                  any_va_q, any_asid_q;

  logic                  latch_ops;
  logic                  inv_all;
  logic                  sweep_en;
  logic                  write_ok;
  logic [TLB_ENTRIES-1:0] valid, match, flush_hit, inv, we;
  logic [1:0]            page_type [TLB_ENTRIES];

  assign FlushBusy = (state_q != StIdle);
  assign FlushDone = (state_q == StDone);
  assign write_ok  = Write & ~FlushBusy;

  for (genvar k = 0; k < TLB_ENTRIES; k++) begin : g_entry
    tlb_cam_entry #(
      .LEVELS       (LEVELS),
      .SEGMENT_BITS (SEGMENT_BITS),
      .ASID_BITS    (ASID_BITS)
    ) u_entry (
      .clk_i            (clk),
      .rst_i            (reset),
      .we_i             (we[k]),
      .inv_i            (inv[k]),
      .vpn_i            (VPN),
      .asid_i           (ASID),
      .g_i              (WriteG),
      .page_type_i      (WritePageType),
      .flush_vpn_i      (flush_vpn_q),
      .flush_asid_i     (flush_asid_q),
      .flush_any_va_i   (any_va_q),
      .flush_any_asid_i (any_asid_q),
      .valid_o          (valid[k]),
      .match_o          (match[k]),
      .flush_hit_o      (flush_hit[k]),
      .page_type_o      (page_type[k])
    );
    assign inv[k] = inv_all | (sweep_en & (idx_q == IdxBits'(k)) & flush_hit[k]);
    assign we[k]  = write_ok & Victim[k];
  end

  // Lookup result
  assign Matches = match;
  assign CAMHit  = (|match) & ~FlushBusy;

  always_comb begin
    HitPageType = '0;
    for (int k = 0; k < TLB_ENTRIES; k++) begin
      if (match[k]) HitPageType |= page_type[k];
    end
  end

  // Victim: fill invalid slots lowest-first, otherwise follow the PLRU tree.
  always_comb begin
    logic               found;
    logic [IdxBits-1:0] node;
    logic [IdxBits-1:0] leaf;
    logic               dir;
    Victim = '0;
    found  = 1'b0;
    for (int k = 0; k < TLB_ENTRIES; k++) begin
      if (!valid[k] && !found) begin
        Victim[k] = 1'b1;
        found     = 1'b1;
      end
    end
    node = '0;
    leaf = '0;
    for (int lvl = 0; lvl < IdxBits; lvl++) begin
      dir  = plru_q[node];
      leaf = (leaf << 1) | IdxBits'(dir);
      node = (node << 1) + IdxBits'(1) + IdxBits'(dir);
    end
    if (!found) Victim = TLB_ENTRIES'(1) << leaf;
  end

  // An accepted write outranks a same-cycle lookup hit.
  always_comb begin
    plru_d = plru_q;
    if (write_ok) begin
      plru_d = plru_touch(plru_q, onehot_to_idx(Victim));
    end else if (Lookup && CAMHit) begin
      plru_d = plru_touch(plru_q, onehot_to_idx(match));
    end
  end

  // Flush sequencer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    latch_ops = 1'b0;
    inv_all   = 1'b0;
    sweep_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (FlushReq) begin
          if (FlushAnyVA && FlushAnyASID) begin
            inv_all = 1'b1;
            state_d = StDone;
          end else begin
            latch_ops = 1'b1;
            idx_d     = '0;
            state_d   = StSweep;
          end
        end
      end
      StSweep: begin
        sweep_en = 1'b1;
        idx_d    = idx_q + IdxBits'(1);
        if (idx_q == IdxBits'(TLB_ENTRIES - 1)) state_d = StDone;
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      plru_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      plru_q  <= plru_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_vpn_q  <= '0;
      flush_asid_q <= '0;
      any_va_q     <= 1'b0;
      any_asid_q   <= 1'b0;
    end else if (latch_ops) begin
      flush_vpn_q  <= FlushVPN;
      flush_asid_q <= FlushASID;
      any_va_q     <= FlushAnyVA;
      any_asid_q   <= FlushAnyASID;
    end
  end

endmodule

// File: tb/tb_tlb_cam_sweep.sv
// Directed self-checking bench for tlb_cam_sweep (8 entries, SV48 defaults).
module tb_tlb_cam_sweep;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] VPN;
  logic [15:0] ASID;
  logic        Lookup, Write, WriteG;
  logic [1:0]  WritePageType;
  logic        FlushReq, FlushAnyVA, FlushAnyASID;
  logic [35:0] FlushVPN;
  logic [15:0] FlushASID;
  logic        FlushBusy, FlushDone, CAMHit;
  logic [7:0]  Matches, Victim;
  logic [1:0]  HitPageType;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_cam_sweep dut (
    .clk           (clk),
    .reset         (reset),
    .VPN           (VPN),
    .ASID          (ASID),
    .Lookup        (Lookup),
    .Write         (Write),
    .WriteG        (WriteG),
    .WritePageType (WritePageType),
    .FlushReq      (FlushReq),
    .FlushAnyVA    (FlushAnyVA),
    .FlushAnyASID  (FlushAnyASID),
    .FlushVPN      (FlushVPN),
    .FlushASID     (FlushASID),
    .FlushBusy     (FlushBusy),
    .FlushDone     (FlushDone),
    .Matches       (Matches),
    .HitPageType   (HitPageType),
    .CAMHit        (CAMHit),
    .Victim        (Victim)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [35:0] vpn, input logic [15:0] asid,
                          input logic g, input logic [1:0] pt);
    VPN = vpn; ASID = asid; WriteG = g; WritePageType = pt; Write = 1'b1;
    tick();
    Write = 1'b0;
  endtask

  // Present a lookup and let the combinational outputs settle.
  task automatic look(input logic [35:0] vpn, input logic [15:0] asid);
    VPN = vpn; ASID = asid;
    #1;
  endtask

  // Qualified lookup across one edge so a hit updates the PLRU tree.
  task automatic hit(input logic [35:0] vpn, input logic [15:0] asid);
    look(vpn, asid);
    Lookup = 1'b1;
    tick();
    Lookup = 1'b0;
  endtask

  task automatic start_flush(input logic any_va, input logic any_asid,
                             input logic [35:0] fvpn, input logic [15:0] fasid);
    FlushAnyVA = any_va; FlushAnyASID = any_asid; FlushVPN = fvpn; FlushASID = fasid;
    FlushReq = 1'b1;
    tick();
    FlushReq = 1'b0;
  endtask

  logic [35:0] ent_vpn [8];
  int          done_cnt;
  int          done_at;
  logic [7:0]  exp_oh;

  initial begin
    reset = 1'b1;
    VPN = '0; ASID = '0; Lookup = 0; Write = 0; WriteG = 0; WritePageType = '0;
    FlushReq = 0; FlushAnyVA = 0; FlushAnyASID = 0; FlushVPN = '0; FlushASID = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_matches", 64'(Matches), 64'h0);
    chk("rst_camhit", 64'(CAMHit), 64'h0);
    chk("rst_hpt", 64'(HitPageType), 64'h0);
    chk("rst_busy", 64'(FlushBusy), 64'h0);
    chk("rst_done", 64'(FlushDone), 64'h0);
    chk("rst_victim", 64'(Victim), 64'h01);
    reset = 1'b0;
    tick();

    // 4 KiB page in entry 0
    ent_vpn[0] = 36'h1_2345_6789;
    do_write(ent_vpn[0], 16'd5, 1'b0, 2'd0);
    look(ent_vpn[0], 16'd5);
    chk("p4k_matches", 64'(Matches), 64'h01);
    chk("p4k_camhit", 64'(CAMHit), 64'h1);
    chk("p4k_hpt", 64'(HitPageType), 64'h0);
    look(ent_vpn[0], 16'd6);
    chk("p4k_asid_miss", 64'(Matches), 64'h00);

    // 2 MiB page in entry 1: segment 0 is ignored
    chk("victim_e1", 64'(Victim), 64'h02);
    ent_vpn[1] = 36'hABC_DE00;
    do_write(ent_vpn[1], 16'd5, 1'b0, 2'd1);
    look(36'hABC_DE1F, 16'd5);
    chk("p2m_matches", 64'(Matches), 64'h02);
    chk("p2m_camhit", 64'(CAMHit), 64'h1);
    chk("p2m_hpt", 64'(HitPageType), 64'h1);
    look(36'hABC_E000, 16'd5);
    chk("p2m_miss", 64'(Matches), 64'h00);
    chk("p2m_miss_camhit", 64'(CAMHit), 64'h0);

    // Fill 2..7; PLRU then points at entry 0 (path of last-written 7, 3, 1 inverted)
    for (int k = 2; k < 8; k++) begin
      ent_vpn[k] = 36'h100 + 36'(k);
      do_write(ent_vpn[k], 16'd5, 1'b0, 2'd0);
    end
    chk("full_victim", 64'(Victim), 64'h01);

    // Hits 0..6: root left (after 6), node1 left (after 3), node3 left (after 1)
    for (int k = 0; k < 7; k++) begin
      exp_oh = 8'h01 << k;
      look(ent_vpn[k], 16'd5);
      chk("hit_seq_matches", 64'(Matches), 64'(exp_oh));
      hit(ent_vpn[k], 16'd5);
    end
    chk("hit06_victim", 64'(Victim), 64'h01);

    // Hits 6,4,5,0,1,2,3: root right, node2 right (after 5), node6 right (after 6)
    hit(ent_vpn[6], 16'd5);
    hit(ent_vpn[4], 16'd5);
    hit(ent_vpn[5], 16'd5);
    for (int k = 0; k < 4; k++) hit(ent_vpn[k], 16'd5);
    chk("plru_victim_e7", 64'(Victim), 64'h80);
    do_write(36'h777, 16'd5, 1'b0, 2'd0);
    look(ent_vpn[7], 16'd5);
    chk("e7_old_gone", 64'(Matches), 64'h00);
    look(36'h777, 16'd5);
    chk("e7_new_hit", 64'(Matches), 64'h80);

    // Flush-all: one edge, then DONE; write during DONE is dropped
    start_flush(1'b1, 1'b1, 36'h0, 16'd0);
    look(36'h777, 16'd5);
    chk("fall_matches", 64'(Matches), 64'h00);
    chk("fall_done", 64'(FlushDone), 64'h1);
    chk("fall_busy", 64'(FlushBusy), 64'h1);
    chk("fall_victim", 64'(Victim), 64'h01);
    do_write(36'h555, 16'd5, 1'b0, 2'd0);
    look(36'h555, 16'd5);
    chk("busy_write_dropped", 64'(Matches), 64'h00);
    chk("fall_done_clear", 64'(FlushDone), 64'h0);
    chk("fall_busy_clear", 64'(FlushBusy), 64'h0);
    chk("fall_victim_after", 64'(Victim), 64'h01);

    // ASID flush of 3 with any VA: G entry and ASID 4 entry survive
    do_write(36'h10, 16'd3, 1'b0, 2'd0);
    do_write(36'h11, 16'd3, 1'b1, 2'd0);
    do_write(36'h12, 16'd4, 1'b0, 2'd0);
    start_flush(1'b1, 1'b0, 36'h0, 16'd3);
    chk("sweep_busy", 64'(FlushBusy), 64'h1);
    look(36'h10, 16'd3);
    chk("sweep_matches", 64'(Matches), 64'h01);
    chk("sweep_camhit_masked", 64'(CAMHit), 64'h0);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 20; c++) begin
      if (FlushDone) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      tick();
    end
    chk("asid_done_count", 64'(done_cnt), 64'd1);
    chk("asid_done_cycle", 64'(done_at), 64'd8);
    chk("asid_busy_clear", 64'(FlushBusy), 64'h0);
    look(36'h10, 16'd3);
    chk("asid_nong_gone", 64'(Matches), 64'h00);
    look(36'h11, 16'd3);
    chk("asid_g_kept", 64'(Matches), 64'h02);
    look(36'h11, 16'd9);
    chk("asid_g_any_asid", 64'(Matches), 64'h02);
    look(36'h12, 16'd4);
    chk("asid_other_kept", 64'(Matches), 64'h04);

    // VA flush of 0x12 across all ASIDs
    start_flush(1'b0, 1'b1, 36'h12, 16'd0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (FlushDone) done_cnt++;
      tick();
    end
    chk("va_done_count", 64'(done_cnt), 64'd1);
    look(36'h12, 16'd4);
    chk("va_target_gone", 64'(Matches), 64'h00);
    look(36'h11, 16'd3);
    chk("va_other_kept", 64'(Matches), 64'h02);

    // Reset in the middle of a sweep (index 3)
    start_flush(1'b1, 1'b0, 36'h0, 16'd7);
    repeat (3) tick();
    chk("mid_busy", 64'(FlushBusy), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    look(36'h11, 16'd3);
    chk("mid_rst_busy", 64'(FlushBusy), 64'h0);
    chk("mid_rst_done", 64'(FlushDone), 64'h0);
    chk("mid_rst_matches", 64'(Matches), 64'h00);
    chk("mid_rst_victim", 64'(Victim), 64'h01);
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (FlushDone || FlushBusy) done_cnt++;
      tick();
    end
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    look(36'h11, 16'd3);
    chk("mid_rst_invalid", 64'(Matches), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
